// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, frames 11-bit
// packets and turns scancode bytes into key events. Optional macro: PS2_KEY_GEN_TIMEOUT_EN.
module ps2_key_gen #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic [1:0]  state_dbg
);
    localparam int FCW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic            clk_filt_q, clk_filt_d;
    logic [FCW-1:0]  filt_cnt_q, filt_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic [2:0]      skip_q, skip_d;
    logic [10:0]     key_q, key_d;
    logic            frame_err_q, frame_err_d;
    logic            fall;
    logic            byte_ok;
    logic            ack_byte;

`ifdef PS2_KEY_GEN_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0]  to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        clk_s1_d    = ps2_clk_in;
        clk_s2_d    = clk_s1_q;
        dat_s1_d    = ps2_dat_in;
        dat_s2_d    = dat_s1_q;
        clk_filt_d  = clk_filt_q;
        filt_cnt_d  = '0;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        skip_d      = skip_q;
        key_d       = key_q;
        frame_err_d = 1'b0;
        byte_ok     = 1'b0;
        ack_byte    = 1'b0;

        // Any sample back at the current level restarts the run of new-level samples.
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end
        fall = clk_filt_q & ~clk_filt_d;

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^{par_q, shift_q})) byte_ok = 1'b1;
                    else frame_err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        ack_byte = (shift_q == 8'hFA) || (shift_q == 8'hAA) || (shift_q == 8'hEE) ||
                   (shift_q == 8'hFE) || (shift_q == 8'hFC);

        if (byte_ok) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE1) begin
                skip_d = 3'd7;
            end else if (!(ack_byte && !ext_q && !brk_q)) begin
                key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

`ifdef PS2_KEY_GEN_TIMEOUT_EN
        // A stalled frame is abandoned; prefix and skip state survive the abort.
        if (fall || state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TOW'(TIMEOUT_CYC - 1)) begin
            to_cnt_d    = '0;
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TOW'(1);
        end
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= 3'd0;
            key_q       <= 11'd0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            key_q       <= key_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PS2_KEY_GEN_TIMEOUT_EN
    always_ff @(posedge clk_sys) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`endif

    assign ps2_key   = key_q;
    assign frame_err = frame_err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed bench for ps2_key_gen: builds PS/2 frames bit by bit and checks key events
// and frame_err pulses against hand-computed values.
module tb_ps2_key_gen;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 50000;
  localparam int HALF        = 20;

  logic        clk_sys    = 1'b0;
  logic        reset      = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic [1:0]  state_dbg;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [10:0] exp_key     = 11'd0;

  // event / error monitor
  int          ev_cnt     = 0;
  int          err_cyc    = 0;
  int          err_pulses = 0;
  logic [10:0] prev_key   = 11'd0;
  logic        prev_err   = 1'b0;

  ps2_key_gen #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err),
    .state_dbg  (state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (ps2_key !== prev_key) ev_cnt++;
    if (frame_err === 1'b1) err_cyc++;
    if (frame_err === 1'b1 && prev_err !== 1'b1) err_pulses++;
    prev_key = ps2_key;
    prev_err = frame_err;
  end

  function automatic logic [10:0] frame_vec(input logic [7:0] b, input logic bad_par,
                                            input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  function automatic logic [10:0] next_key(input logic [10:0] cur, input logic [7:0] b,
                                           input logic brk, input logic ext);
    return {~cur[10], ~brk, ext, b};
  endfunction

  task automatic send_range(input logic [10:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk_sys);
      ps2_dat_in = v[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_range(frame_vec(b, bad_par, stop), 0, 10);
    @(negedge clk_sys);
    ps2_dat_in = 1'b1;
    repeat (HALF) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk_sys);
    vectors++;
    if (ps2_key !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_key: got %h want %h", ps2_key, 11'd0);
    end
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b want 0", frame_err);
    end
    vectors++;
    if (state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    exp_key = 11'd0;
  endtask

  task automatic test_single_make();
    int ev0;
    int er0;
    int lat;
    ev0 = ev_cnt;
    er0 = err_pulses;
    send_range(frame_vec(8'h1C, 1'b0, 1'b1), 0, 9);
    @(negedge clk_sys);
    ps2_dat_in = 1'b1;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk_in = 1'b0;
    lat = 0;
    // 2 synchronizer stages + FILTER_LEN filter samples from the raw fall
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_sys);
      #1;
      if (lat == 0 && ps2_key !== 11'd0) lat = n;
    end
    @(negedge clk_sys);
    ps2_clk_in = 1'b1;
    repeat (HALF) @(negedge clk_sys);
    exp_key = 11'b1_1_0_0001_1100;
    vectors++;
    if (lat != 2 + FILTER_LEN) begin
      miscompares++;
      $display("FAIL single_latency: got %0d want %0d", lat, 2 + FILTER_LEN);
    end
    vectors++;
    if (ps2_key !== exp_key) begin
      miscompares++;
      $display("FAIL single_key: got %h want %h", ps2_key, exp_key);
    end
    vectors++;
    if (ev_cnt - ev0 != 1 || err_pulses != er0) begin
      miscompares++;
      $display("FAIL single_counts: got ev %0d err %0d want ev 1 err 0", ev_cnt - ev0,
               err_pulses - er0);
    end
  endtask

  task automatic test_break();
    int ev0;
    ev0 = ev_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    vectors++;
    if (ev_cnt != ev0 || ps2_key !== exp_key) begin
      miscompares++;
      $display("FAIL break_prefix: got key %h ev %0d want key %h ev 0", ps2_key,
               ev_cnt - ev0, exp_key);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_key = next_key(exp_key, 8'h1C, 1'b1, 1'b0);
    vectors++;
    if (ps2_key !== exp_key || ev_cnt - ev0 != 1) begin
      miscompares++;
      $display("FAIL break_release: got key %h ev %0d want key %h ev 1", ps2_key,
               ev_cnt - ev0, exp_key);
    end
  endtask

  task automatic test_extended();
    int ev0;
    ev0 = ev_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    exp_key = next_key(exp_key, 8'h75, 1'b1, 1'b1);
    vectors++;
    if (ps2_key !== exp_key || ev_cnt - ev0 != 1) begin
      miscompares++;
      $display("FAIL ext_release: got key %h ev %0d want key %h ev 1", ps2_key,
               ev_cnt - ev0, exp_key);
    end
    send_frame(8'h75, 1'b0, 1'b1);
    exp_key = next_key(exp_key, 8'h75, 1'b0, 1'b0);
    vectors++;
    if (ps2_key !== exp_key) begin
      miscompares++;
      $display("FAIL ext_flags_cleared: got %h want %h", ps2_key, exp_key);
    end
  endtask

  task automatic test_frame_error();
    int er0;
    int ec0;
    int ev0;
    er0 = err_pulses;
    ec0 = err_cyc;
    ev0 = ev_cnt;
    send_frame(8'h29, 1'b1, 1'b1);
    vectors++;
    if (err_pulses - er0 != 1 || err_cyc - ec0 != 1) begin
      miscompares++;
      $display("FAIL parity_err_pulse: got pulses %0d cycles %0d want 1 1",
               err_pulses - er0, err_cyc - ec0);
    end
    vectors++;
    if (ps2_key !== exp_key || ev_cnt != ev0) begin
      miscompares++;
      $display("FAIL parity_err_key: got %h want %h", ps2_key, exp_key);
    end
    send_frame(8'h29, 1'b0, 1'b0);
    vectors++;
    if (err_pulses - er0 != 2 || ev_cnt != ev0) begin
      miscompares++;
      $display("FAIL stop_err: got pulses %0d ev %0d want 2 0", err_pulses - er0,
               ev_cnt - ev0);
    end
    send_frame(8'h29, 1'b0, 1'b1);
    exp_key = next_key(exp_key, 8'h29, 1'b0, 1'b0);
    vectors++;
    if (ps2_key !== exp_key || err_pulses - er0 != 2) begin
      miscompares++;
      $display("FAIL err_recover: got %h want %h", ps2_key, exp_key);
    end
  endtask

  task automatic test_ack_bytes();
    int ev0;
    ev0 = ev_cnt;
    send_frame(8'hFA, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    vectors++;
    if (ev_cnt != ev0 || ps2_key !== exp_key) begin
      miscompares++;
      $display("FAIL ack_discard: got key %h ev %0d want key %h ev 0", ps2_key,
               ev_cnt - ev0, exp_key);
    end
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hFA, 1'b0, 1'b1);
    exp_key = next_key(exp_key, 8'hFA, 1'b0, 1'b1);
    vectors++;
    if (ps2_key !== exp_key) begin
      miscompares++;
      $display("FAIL ack_with_prefix: got %h want %h", ps2_key, exp_key);
    end
  endtask

  task automatic test_glitch_skip();
    int ev0;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    ev0 = ev_cnt;
    ps2_dat_in = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
      repeat (15) @(negedge clk_sys);
    end
    vectors++;
    if (state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL glitch_state: got %0d want 0", state_dbg);
    end
    ps2_dat_in = 1'b1;
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 1'b1);
    vectors++;
    if (ev_cnt != ev0 || ps2_key !== exp_key) begin
      miscompares++;
      $display("FAIL skip_discard: got key %h ev %0d want key %h ev 0", ps2_key,
               ev_cnt - ev0, exp_key);
    end
    send_frame(8'h16, 1'b0, 1'b1);
    exp_key = next_key(exp_key, 8'h16, 1'b0, 1'b0);
    vectors++;
    if (ps2_key !== exp_key || ev_cnt - ev0 != 1) begin
      miscompares++;
      $display("FAIL skip_after: got key %h ev %0d want key %h ev 1", ps2_key,
               ev_cnt - ev0, exp_key);
    end
  endtask

  task automatic test_reset_mid_frame();
    int er0;
    er0 = err_pulses;
    send_range(frame_vec(8'h1C, 1'b0, 1'b1), 0, 4);
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    exp_key = 11'd0;
    vectors++;
    if (ps2_key !== exp_key || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_state: got key %h state %0d want key 0 state 0", ps2_key,
               state_dbg);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_key = 11'h61C;
    vectors++;
    if (ps2_key !== exp_key || err_pulses != er0) begin
      miscompares++;
      $display("FAIL midreset_next: got key %h err %0d want key %h err 0", ps2_key,
               err_pulses - er0, exp_key);
    end
  endtask

`ifdef PS2_KEY_GEN_TIMEOUT_EN
  task automatic test_timeout();
    int er0;
    int ec0;
    er0 = err_pulses;
    ec0 = err_cyc;
    send_range(frame_vec(8'h1C, 1'b0, 1'b1), 0, 3);
    repeat (TIMEOUT_CYC + 50) @(negedge clk_sys);
    vectors++;
    if (err_pulses - er0 != 1 || err_cyc - ec0 != 1 || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL timeout_abort: got pulses %0d cycles %0d state %0d want 1 1 0",
               err_pulses - er0, err_cyc - ec0, state_dbg);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_key = next_key(exp_key, 8'h1C, 1'b0, 1'b0);
    vectors++;
    if (ps2_key !== exp_key) begin
      miscompares++;
      $display("FAIL timeout_next: got %h want %h", ps2_key, exp_key);
    end
  endtask
`else
  task automatic test_partial_wait();
    int er0;
    int ev0;
    logic [10:0] v;
    er0 = err_pulses;
    ev0 = ev_cnt;
    v = frame_vec(8'h1C, 1'b0, 1'b1);
    send_range(v, 0, 3);
    repeat (300) @(negedge clk_sys);
    vectors++;
    if (err_pulses != er0 || ev_cnt != ev0 || state_dbg !== 2'd1) begin
      miscompares++;
      $display("FAIL partial_wait: got err %0d ev %0d state %0d want 0 0 1",
               err_pulses - er0, ev_cnt - ev0, state_dbg);
    end
    send_range(v, 4, 10);
    repeat (HALF) @(negedge clk_sys);
    exp_key = next_key(exp_key, 8'h1C, 1'b0, 1'b0);
    vectors++;
    if (ps2_key !== exp_key || err_pulses != er0) begin
      miscompares++;
      $display("FAIL partial_complete: got %h want %h", ps2_key, exp_key);
    end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_extended();
    test_frame_error();
    test_ack_bytes();
    test_glitch_skip();
    test_reset_mid_frame();
`ifdef PS2_KEY_GEN_TIMEOUT_EN
    test_timeout();
`else
    test_partial_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_key_gen.md
PS2_KEY_GEN -- requirements
Module: ps2_key_gen

Interface
REQ-001 Parameter FILTER_LEN, default 8, consecutive equal synchronized samples needed to accept a new PS/2 clock level.
REQ-002 Parameter TIMEOUT_CYC, default 50000, clk_sys cycles without a filtered falling edge before an open frame is aborted.
REQ-003 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk_in  input  1  raw keyboard clock line, asynchronous, idle high.
REQ-006 ps2_dat_in  input  1  raw keyboard data line, asynchronous, idle high.
REQ-007 ps2_key  output  11  key event: [10] toggle, [9] pressed, [8] extended (E0), [7:0] scancode.
REQ-008 frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-009 Both raw lines SHALL pass a 2-flop synchronizer before any use.
REQ-010 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level.
REQ-011 Data SHALL be sampled on the cycle the filtered clock goes 1->0.
REQ-012 Frame FSM states IDLE, DATA, PARITY, STOP; each transition occurs only on a filtered falling edge.
REQ-013 IDLE: sampled data 0 -> DATA with bit counter 0; sampled 1 -> stay IDLE, no error.
REQ-014 DATA: shift 8 bits LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: store bit; -> STOP.
REQ-016 STOP: frame valid iff stop bit 1 and the 9 bits (data+parity) have odd parity; always -> IDLE.
REQ-017 Invalid frame: byte discarded, frame_err high exactly one cycle after the stop-bit sample, prefix flags unchanged.
REQ-018 Valid byte SHALL be handled one cycle after the stop-bit sample.
REQ-019 Byte E0 sets ext flag; F0 sets brk flag; neither emits an event.
REQ-020 Byte E1 sets a skip counter to 7; the next 7 valid bytes are discarded without events or flag changes.
REQ-021 Bytes FA, AA, EE, FE, FC received with both flags clear SHALL be discarded without an event.
REQ-022 Any other byte emits an event: ps2_key[7:0]=byte, [9]=~brk, [8]=ext, [10] inverted; both flags cleared in the same cycle.
REQ-023 ps2_key[9:0] and ps2_key[10] SHALL update in the same cycle; ps2_key holds until the next event.
REQ-024 Events are never dropped: at most one byte completes per 11 filtered clock periods, so no queue is required.

Reset
REQ-025 Reset SHALL force ps2_key=0, frame_err=0, FSM=IDLE, bit counter=0, ext=brk=0, skip counter=0.
REQ-026 Reset SHALL set the filtered clock and both synchronizer stages to 1 and the filter counter to 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame without a frame_err pulse.

Configuration
REQ-028 Macro PS2_KEY_GEN_TIMEOUT_EN defined: a counter restarts on each filtered falling edge and runs while FSM is not IDLE.
REQ-029 With the macro defined, reaching TIMEOUT_CYC SHALL force IDLE and pulse frame_err one cycle; prefix and skip state are kept.
REQ-030 Macro undefined: no timeout counter exists, and an incomplete frame waits indefinitely for further clock edges.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 -> one cycle after stop sample ps2_key=11'b1_1_0_0001_1100 from reset value 0.
REQ-032 Frames F0,1C -> ps2_key[10] toggles once; ps2_key[9:0]=10'b0_0_0001_1100; no event after F0.
REQ-033 Frames E0,F0,75 -> single event with [9]=0, [8]=1, [7:0]=0x75; next frame 0x75 -> [9]=1, [8]=0.
REQ-034 Frame 0x29 with parity bit 1 (even) -> frame_err pulse of 1 cycle, ps2_key unchanged; following valid 0x29 -> event with [9]=1.
REQ-035 Glitches of FILTER_LEN-1 cycles on ps2_clk_in -> no bit sampled; E1,14,77,E1,F0,14,F0,77 then 0x16 -> only the 0x16 event appears.
REQ-036 With PS2_KEY_GEN_TIMEOUT_EN defined: start bit plus 3 data bits, then idle TIMEOUT_CYC cycles -> frame_err pulse; next full 0x1C frame -> correct event.
